// File: rtl/hazard_stall_ctrl.sv
// Stall and sequencing controller for a 5-stage MIPS pipe: Tuse/Tnew data hazards,
// multiply/divide busy sequencing, PC/FD enables, D/E bubble and a stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  tuse_rs,
   input  logic [1:0]  tuse_rt,
   input  logic [4:0]  a3_E,
   input  logic [1:0]  tnew_E,
   input  logic [4:0]  a3_M,
   input  logic [1:0]  tnew_M,
   input  logic        md_op_D,
   input  logic        md_start_E,
   input  logic        md_kind_E,
   output logic        en_PC,
   output logic        en_FD,
   output logic        clr_DE,
   output logic        md_busy,
   output logic        md_done,
   output logic        md_err,
   output logic [31:0] stall_cnt
);

   typedef enum logic [0:0] {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_err_q, md_err_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall_raw;
   logic stall_act;

   // A source register stalls when a producer in E or M writes it and its result
   // will not be ready by the time D needs it; $zero never carries a dependency.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] dst_e,
      input logic [1:0] tnew_e,
      input logic [4:0] dst_m,
      input logic [1:0] tnew_m
   );
      logic hit_e;
      logic hit_m;
      hit_e = (src == dst_e) && (tnew_e > tuse);
      hit_m = (src == dst_m) && (tnew_m > tuse);
      return (src != 5'd0) && (hit_e || hit_m);
   endfunction

   always_comb begin
      stall_rs  = src_hazard(rs_D, tuse_rs, a3_E, tnew_E, a3_M, tnew_M);
      stall_rt  = src_hazard(rt_D, tuse_rt, a3_E, tnew_E, a3_M, tnew_M);
      stall_md  = md_op_D && (md_busy || md_start_E);
      stall_raw = stall_rs | stall_rt | stall_md;
      // Reset overrides the pipeline controls so the front end keeps flowing.
      stall_act = stall_raw & reset;
   end

   always_comb begin
      en_PC  = ~stall_act;
      en_FD  = ~stall_act;
      clr_DE = stall_act;
   end

   always_comb begin
      md_busy   = (state_q == MD_BUSY);
      md_done   = (state_q == MD_BUSY) && (cnt_q == CNT_LAST);
      md_err    = md_err_q;
      stall_cnt = stall_cnt_q;
   end

   // Multiply/divide sequencer; a start seen while busy (including the final
   // busy cycle) is dropped and only latches the sticky error flag.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_err_d = md_err_q;
      unique case (state_q)
         MD_IDLE: begin
            if (md_start_E) begin
               cnt_d   = md_kind_E ? DIV_LOAD : MULT_LOAD;
               state_d = MD_BUSY;
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
               state_d = MD_IDLE;
            end
            if (md_start_E) begin
               md_err_d = 1'b1;
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_raw && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= MD_IDLE;
         cnt_q       <= '0;
         md_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         md_err_q    <= md_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  rs_D, rt_D, a3_E, a3_M;
   logic [1:0]  tuse_rs, tuse_rt, tnew_E, tnew_M;
   logic        md_op_D, md_start_E, md_kind_E;
   logic        en_PC, en_FD, clr_DE, md_busy, md_done, md_err;
   logic [31:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_stall_ctrl #(
      .MULT_LAT(5),
      .DIV_LAT (10),
      .CNT_W   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rs_D      (rs_D),
      .rt_D      (rt_D),
      .tuse_rs   (tuse_rs),
      .tuse_rt   (tuse_rt),
      .a3_E      (a3_E),
      .tnew_E    (tnew_E),
      .a3_M      (a3_M),
      .tnew_M    (tnew_M),
      .md_op_D   (md_op_D),
      .md_start_E(md_start_E),
      .md_kind_E (md_kind_E),
      .en_PC     (en_PC),
      .en_FD     (en_FD),
      .clr_DE    (clr_DE),
      .md_busy   (md_busy),
      .md_done   (md_done),
      .md_err    (md_err),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs_D = '0; rt_D = '0; tuse_rs = 2'd3; tuse_rt = 2'd3;
      a3_E = '0; tnew_E = '0; a3_M = '0; tnew_M = '0;
      md_op_D = 1'b0; md_start_E = 1'b0; md_kind_E = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      rs_D = 5'd8; a3_E = 5'd8; tnew_E = 2'd2; tuse_rs = 2'd0;
      md_op_D = 1'b1; md_start_E = 1'b1;
      #2;
      checks++; if (en_PC !== 1'b1) begin failures++; $display("FAIL rst_en_pc got=%b exp=1", en_PC); end
      checks++; if (en_FD !== 1'b1) begin failures++; $display("FAIL rst_en_fd got=%b exp=1", en_FD); end
      checks++; if (clr_DE !== 1'b0) begin failures++; $display("FAIL rst_clr_de got=%b exp=0", clr_DE); end
      tick();
      tick();
      checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_stall_cnt got=%h exp=0", stall_cnt); end
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL rst_md_busy got=%b exp=0", md_busy); end
      checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL rst_md_done got=%b exp=0", md_done); end
      checks++; if (md_err !== 1'b0) begin failures++; $display("FAIL rst_md_err got=%b exp=0", md_err); end
      idle_inputs();
      reset = 1'b1;
      #1;
      checks++; if (en_PC !== 1'b1) begin failures++; $display("FAIL rst_idle_en_pc got=%b exp=1", en_PC); end
   endtask

   task automatic test_load_use();
      rs_D = 5'd8; a3_E = 5'd8; tnew_E = 2'd2; tuse_rs = 2'd1;
      #1;
      checks++; if (en_PC !== 1'b0) begin failures++; $display("FAIL lu_en_pc got=%b exp=0", en_PC); end
      checks++; if (en_FD !== 1'b0) begin failures++; $display("FAIL lu_en_fd got=%b exp=0", en_FD); end
      checks++; if (clr_DE !== 1'b1) begin failures++; $display("FAIL lu_clr_de got=%b exp=1", clr_DE); end
      tick();
      tnew_E = 2'd1;
      #1;
      checks++; if (en_PC !== 1'b1) begin failures++; $display("FAIL lu_clear_en_pc got=%b exp=1", en_PC); end
      checks++; if (clr_DE !== 1'b0) begin failures++; $display("FAIL lu_clear_clr_de got=%b exp=0", clr_DE); end
      checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
      tick();
      idle_inputs();
      rt_D = 5'd9; a3_M = 5'd9; tnew_M = 2'd1; tuse_rt = 2'd0;
      #1;
      checks++; if (clr_DE !== 1'b1) begin failures++; $display("FAIL rt_m_clr_de got=%b exp=1", clr_DE); end
      tick();
      checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL rt_m_stall_cnt got=%0d exp=2", stall_cnt); end
      tuse_rt = 2'd1;
      #1;
      checks++; if (en_FD !== 1'b1) begin failures++; $display("FAIL tnew_eq_tuse_en_fd got=%b exp=1", en_FD); end
      tick();
      idle_inputs();
   endtask

   task automatic test_reg_zero();
      rs_D = 5'd0; a3_E = 5'd0; tnew_E = 2'd2; tuse_rs = 2'd0;
      rt_D = 5'd0; a3_M = 5'd0; tnew_M = 2'd3; tuse_rt = 2'd0;
      #1;
      checks++; if (en_FD !== 1'b1) begin failures++; $display("FAIL reg0_en_fd got=%b exp=1", en_FD); end
      checks++; if (clr_DE !== 1'b0) begin failures++; $display("FAIL reg0_clr_de got=%b exp=0", clr_DE); end
      tick();
      checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL reg0_stall_cnt got=%0d exp=2", stall_cnt); end
      idle_inputs();
   endtask

   task automatic test_mult();
      apply_reset();
      md_op_D = 1'b1; md_start_E = 1'b1; md_kind_E = 1'b0;
      #1;
      checks++; if (clr_DE !== 1'b1) begin failures++; $display("FAIL mult_start_clr_de got=%b exp=1", clr_DE); end
      tick();
      md_start_E = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         #1;
         checks++; if (md_busy !== 1'b1) begin failures++; $display("FAIL mult_busy cyc=%0d got=%b exp=1", i, md_busy); end
         checks++; if (md_done !== (i == 5)) begin failures++; $display("FAIL mult_done cyc=%0d got=%b exp=%b", i, md_done, (i == 5)); end
         checks++; if (en_PC !== 1'b0) begin failures++; $display("FAIL mult_en_pc cyc=%0d got=%b exp=0", i, en_PC); end
         tick();
      end
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL mult_end_busy got=%b exp=0", md_busy); end
      checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL mult_end_done got=%b exp=0", md_done); end
      checks++; if (en_PC !== 1'b1) begin failures++; $display("FAIL mult_end_en_pc got=%b exp=1", en_PC); end
      checks++; if (stall_cnt !== 32'd6) begin failures++; $display("FAIL mult_stall_cnt got=%0d exp=6", stall_cnt); end
      md_op_D = 1'b0;
   endtask

   task automatic test_back_to_back();
      md_start_E = 1'b1; md_kind_E = 1'b0;
      tick();
      md_start_E = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         checks++; if (md_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", i, md_busy); end
         if (i == 5) md_start_E = 1'b1;
         tick();
      end
      md_start_E = 1'b0;
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL b2b_late_start_busy got=%b exp=0", md_busy); end
      checks++; if (md_err !== 1'b1) begin failures++; $display("FAIL b2b_late_start_err got=%b exp=1", md_err); end
      checks++; if (stall_cnt !== 32'd6) begin failures++; $display("FAIL b2b_stall_cnt got=%0d exp=6", stall_cnt); end
   endtask

   task automatic test_div();
      apply_reset();
      md_start_E = 1'b1; md_kind_E = 1'b1;
      tick();
      md_start_E = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 4) begin md_start_E = 1'b1; md_kind_E = 1'b0; end
         #1;
         checks++; if (md_busy !== 1'b1) begin failures++; $display("FAIL div_busy cyc=%0d got=%b exp=1", i, md_busy); end
         checks++; if (md_done !== (i == 10)) begin failures++; $display("FAIL div_done cyc=%0d got=%b exp=%b", i, md_done, (i == 10)); end
         checks++; if (md_err !== (i > 4)) begin failures++; $display("FAIL div_err cyc=%0d got=%b exp=%b", i, md_err, (i > 4)); end
         tick();
         md_start_E = 1'b0;
      end
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL div_end_busy got=%b exp=0", md_busy); end
      checks++; if (md_err !== 1'b1) begin failures++; $display("FAIL div_end_err got=%b exp=1", md_err); end
      checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL div_stall_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_reset_mid_div();
      apply_reset();
      md_op_D = 1'b1; md_start_E = 1'b1; md_kind_E = 1'b1;
      tick();
      md_start_E = 1'b0;
      tick();
      md_start_E = 1'b1;
      tick();
      md_start_E = 1'b0;
      #1;
      checks++; if (md_err !== 1'b1) begin failures++; $display("FAIL rmd_pre_err got=%b exp=1", md_err); end
      checks++; if (md_busy !== 1'b1) begin failures++; $display("FAIL rmd_pre_busy got=%b exp=1", md_busy); end
      reset = 1'b0;
      #1;
      checks++; if (en_PC !== 1'b1) begin failures++; $display("FAIL rmd_en_pc got=%b exp=1", en_PC); end
      checks++; if (clr_DE !== 1'b0) begin failures++; $display("FAIL rmd_clr_de got=%b exp=0", clr_DE); end
      tick();
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL rmd_busy got=%b exp=0", md_busy); end
      checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL rmd_done got=%b exp=0", md_done); end
      checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rmd_stall_cnt got=%0d exp=0", stall_cnt); end
      checks++; if (md_err !== 1'b0) begin failures++; $display("FAIL rmd_err got=%b exp=0", md_err); end
      tick();
      checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL rmd_done2 got=%b exp=0", md_done); end
      checks++; if (en_FD !== 1'b1) begin failures++; $display("FAIL rmd_en_fd got=%b exp=1", en_FD); end
      reset = 1'b1;
      idle_inputs();
   endtask

   task automatic test_saturation();
      apply_reset();
      rs_D = 5'd8; a3_E = 5'd8; tnew_E = 2'd2; tuse_rs = 2'd1;
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      tick();
      checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffffffff", stall_cnt); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold cyc=%0d got=%h exp=ffffffff", i, stall_cnt); end
      end
      idle_inputs();
      tick();
      checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_idle got=%h exp=ffffffff", stall_cnt); end
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      test_reset();
      test_load_use();
      test_reg_zero();
      test_mult();
      test_back_to_back();
      test_div();
      test_reset_mid_div();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall and sequencing controller for the F/D pipeline register and the rest of the 5-stage MIPS pipe.
- Detects Tuse/Tnew data hazards between D and the E/M stages.
- Sequences the multi-cycle multiply/divide unit with a busy counter FSM.
- Drives the PC/FD enables and the D/E bubble (clear), and keeps a saturating stall-cycle counter for performance checks.

Parameters:
MULT_LAT, 5, busy cycles for mult/multu
DIV_LAT, 10, busy cycles for div/divu
CNT_W, 4, width of MD countdown counter (must hold DIV_LAT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low (0 = reset)
rs_D  in  5  rs field of instruction in D
rt_D  in  5  rt field of instruction in D
tuse_rs  in  2  cycles until D instruction needs rs (3 = not used)
tuse_rt  in  2  cycles until D instruction needs rt (3 = not used)
a3_E  in  5  destination register of instruction in E
tnew_E  in  2  cycles until E result is available
a3_M  in  5  destination register of instruction in M
tnew_M  in  2  cycles until M result is available
md_op_D  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo
md_start_E  in  1  E holds mult/multu/div/divu this cycle
md_kind_E  in  1  0 = mult class, 1 = div class
en_PC  out  1  PC write enable
en_FD  out  1  F/D register enable
clr_DE  out  1  insert bubble into D/E register
md_busy  out  1  MD unit computing
md_done  out  1  last busy cycle of MD operation
md_err  out  1  sticky: md_start_E seen while busy
stall_cnt  out  32  count of stalled cycles

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE, countdown=0, stall_cnt=0, md_err=0.
- While reset==0 the combinational outputs are forced: en_PC=1, en_FD=1, clr_DE=0. md_busy and md_done read 0 once reset has been sampled.
- Data hazard, combinational:
  - stall_rs = rs_D!=0 && ((rs_D==a3_E && tnew_E>tuse_rs) || (rs_D==a3_M && tnew_M>tuse_rs)).
  - stall_rt is the same expression using rt_D and tuse_rt.
  - A match on register 0 never stalls.
- MD hazard, combinational: stall_md = md_op_D && (md_busy || md_start_E).
- stall = stall_rs | stall_rt | stall_md. Outputs: en_PC = en_FD = ~stall; clr_DE = stall.
- All outputs are valid in the same cycle as their inputs (zero latency); only state is registered.
- MD FSM, states IDLE and BUSY:
  - IDLE: on md_start_E=1, load countdown with MULT_LAT (kind 0) or DIV_LAT (kind 1), then go to BUSY.
  - BUSY: countdown decrements by 1 per cycle. When countdown==1 at a posedge, return to IDLE.
  - md_busy=1 exactly while in BUSY, i.e. for LAT consecutive cycles starting the cycle after the start edge.
  - md_done = BUSY && countdown==1: a single-cycle pulse in the last busy cycle.
  - md_start_E=1 while in BUSY (illegal; the pipeline prevents it): the start is ignored, the countdown continues, and md_err is set to 1 and held until reset.
  - md_start_E on the same cycle the FSM returns to IDLE (countdown==1) is also illegal and handled the same way.
- stall_cnt: increments by 1 on each posedge where stall==1 and reset==1. It saturates at 32'hFFFFFFFF and never wraps.
- Reset mid-operation: the FSM aborts to IDLE immediately and md_busy drops in the next cycle. No md_done is generated.

Test Plan:
1. Load-use: a3_E=8, tnew_E=2, rs_D=8, tuse_rs=1 -> en_PC=en_FD=0, clr_DE=1. Set tnew_E=1 next cycle -> stall clears; stall_cnt=1.
2. Register 0: rs_D=0, a3_E=0, tnew_E=2, tuse_rs=0 -> no stall, en_FD=1.
3. Mult sequence: md_start_E=1, kind=0 for one cycle -> md_busy=1 for exactly 5 cycles and md_done high in the 5th only. md_op_D=1 across the window -> stalled 6 cycles (start cycle + 5 busy); stall_cnt=6.
4. Div latency: kind=1 start -> md_busy for 10 cycles. An illegal start at busy cycle 4 -> md_err=1, busy still ends at cycle 10.
5. Reset mid-div: assert reset=0 at busy cycle 3 -> next cycle md_busy=0, stall_cnt=0, md_err=0. No md_done pulse. en_PC=1 while reset is low.
6. Saturation: force stall for 2^32+3 cycles, or preload via the bench's hierarchical force to FFFFFFFE -> count reaches FFFFFFFF and holds.
